// File: rtl/proc_pkg.sv
// Shared processor-datapath definitions: immediate extension modes and the
// occupancy encoding used by two-entry valid/ready skid buffers.
package proc_pkg;

  localparam logic [1:0] IMM_ZERO   = 2'b00;
  localparam logic [1:0] IMM_SIGN   = 2'b01;
  localparam logic [1:0] IMM_UPPER  = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage : proc_pkg

// File: rtl/imm_extend_pipe_if.sv
// Immediate-extender bus: upstream valid/ready input side and downstream
// valid/ready output side. The producer/consumer (bench or neighbouring
// stages) uses master; the extender itself uses slave.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface : imm_extend_pipe_if

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// The main register drives the output; the skid register catches the one
// extra beat that can arrive while the consumer stalls. in_ready is a flop
// computed from the next occupancy, so no combinational path runs from
// out_ready back to in_ready.
module skid_buf2
  import proc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_state_t   state_p1;
  occ_state_t   state_nxt;
  logic [W-1:0] main_p1;
  logic [W-1:0] skid_p1;
  logic         rdy_p1;
  logic         accept;
  logic         consume;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid;

  assign accept  = in_valid & rdy_p1;
  assign consume = (state_p1 != EMPTY) & out_ready;

  // Next occupancy and register-load strobes; flush overrides everything.
  always_comb begin
    state_nxt      = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_p1)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end
      end
      FULL: begin
        if (consume) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Occupancy state and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= EMPTY;
      rdy_p1   <= 1'b1;
    end else begin
      state_p1 <= state_nxt;
      rdy_p1   <= (state_nxt != FULL);
    end
  end

  // Entry storage; main only changes when a new beat is taken or the skid
  // beat is promoted, so output data is stable during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_in) begin
        main_p1 <= in_data;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= in_data;
      end
    end
  end

  // --- stage p1 boundary: registered outputs ---
  assign in_ready  = rdy_p1;
  assign out_valid = (state_p1 != EMPTY);
  assign out_data  = main_p1;

endmodule : skid_buf2

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: widens an IN_W-bit immediate to OUT_W bits
// (zero, sign, upper-load or shifted branch offset) and hands it, with its
// tag, to the ALU/branch stage through a two-entry skid buffer.
module imm_extend_pipe
  import proc_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  imm_extend_pipe_if.slave bus
);

  localparam int W = OUT_W + TAG_W;

  // Reject parameter sets for which the extension is undefined.
  if (IN_W < 2 || OUT_W <= IN_W || BR_SHIFT < 0 || BR_SHIFT > OUT_W - IN_W) begin : g_bad_params
    $error("imm_extend_pipe: illegal IN_W/OUT_W/BR_SHIFT combination");
  end

  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic signed [OUT_W-1:0] sext;
    logic        [OUT_W-1:0] res;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    res  = '0;
    case (mode)
      IMM_ZERO:   res = {{(OUT_W-IN_W){1'b0}}, imm};
      IMM_SIGN:   res = $unsigned(sext);
      IMM_UPPER:  res = {imm, {(OUT_W-IN_W){1'b0}}};
      IMM_BRANCH: res = $unsigned(sext <<< BR_SHIFT);
      default:    res = '0;
    endcase
    return res;
  endfunction

  logic [OUT_W-1:0] ext_p0;
  logic [W-1:0]     pack_p0;
  logic [W-1:0]     pack_p1;

  // --- stage p0: combinational extension of the presented immediate ---
  assign ext_p0  = extend_imm(bus.in_imm, bus.in_mode);
  assign pack_p0 = {ext_p0, bus.in_tag};

  skid_buf2 #(
    .W (W)
  ) u_skid (
    .clk       (clk),
    .rst       (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pack_p0),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pack_p1)
  );

  // --- stage p1: captured operand and tag ---
  assign bus.out_data = pack_p1[W-1:TAG_W];
  assign bus.out_tag  = pack_p1[TAG_W-1:0];

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe (IN_W=16, OUT_W=32, BR_SHIFT=2, TAG_W=5).
module tb_imm_extend_pipe;

  logic clk;
  logic reset;
  logic flush;
  int   checks;
  int   errors;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

  imm_extend_pipe #(
    .IN_W     (16),
    .OUT_W    (32),
    .BR_SHIFT (2),
    .TAG_W    (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] i, input logic [4:0] t);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_imm   = i;
    bus.in_tag   = t;
  endtask

  task automatic test_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag got %0d exp 0", bus.out_tag); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_modes();
    logic [1:0]  md [7];
    logic [15:0] im [7];
    logic [4:0]  tg [7];
    logic [31:0] ex [7];
    md = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
    im = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
    tg = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd30, 5'd31};
    ex = '{32'hFFFF_8001, 32'h0000_8001, 32'h1234_0000, 32'hFFFF_FFFC,
           32'h0000_7FFF, 32'hFFFE_0000, 32'h0000_FFFF};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, md[k], im[k], tg[k]);
      step();
      drive(1'b0, 2'b00, 16'h0, 5'd0);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_data !== ex[k]) begin errors++; $display("FAIL mode%0d_data got %h exp %h", k, bus.out_data, ex[k]); end
      checks++; if (bus.out_tag !== tg[k]) begin errors++; $display("FAIL mode%0d_tag got %0d exp %0d", k, bus.out_tag, tg[k]); end
      step();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL modes_drained got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b01, 16'h0001, 5'd1);
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1 got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0000_0001) begin errors++; $display("FAIL bp_data_a got %h exp 00000001", bus.out_data); end
    drive(1'b1, 2'b00, 16'hABCD, 5'd2);
    step();
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_full got %b exp 1", bus.out_valid); end
    step();
    step();
    checks++; if (bus.out_data !== 32'h0000_0001) begin errors++; $display("FAIL bp_data_held got %h exp 00000001", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd1) begin errors++; $display("FAIL bp_tag_held got %0d exp 1", bus.out_tag); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held got %b exp 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_consume got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_b got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0000_ABCD) begin errors++; $display("FAIL bp_data_b got %h exp 0000abcd", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd2) begin errors++; $display("FAIL bp_tag_b got %0d exp 2", bus.out_tag); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  md [8];
    logic [15:0] im [8];
    logic [31:0] ex [8];
    md = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    im = '{16'h0001, 16'hFFFE, 16'h00FF, 16'h0001, 16'h4000, 16'h8000, 16'hFFFF, 16'h7FFF};
    ex = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h00FF_0000, 32'h0000_0004,
           32'h0000_4000, 32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_7FFF};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, md[k], im[k], 5'(k + 8));
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_data !== ex[k]) begin errors++; $display("FAIL b2b%0d_data got %h exp %h", k, bus.out_data, ex[k]); end
      checks++; if (bus.out_tag !== 5'(k + 8)) begin errors++; $display("FAIL b2b%0d_tag got %0d exp %0d", k, bus.out_tag, k + 8); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got %b exp 1", k, bus.in_ready); end
    end
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h1111, 5'd4);
    step();
    drive(1'b1, 2'b00, 16'h2222, 5'd5);
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fl_full_ready got %b exp 0", bus.in_ready); end
    drive(1'b1, 2'b00, 16'h3333, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_full_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fl_full_ready_after got %b exp 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_ghost got %b exp 0", bus.out_valid); end
    // flush with a live accept in ONE: the offered beat must be dropped
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h4444, 5'd7);
    step();
    drive(1'b1, 2'b00, 16'h5555, 5'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fl_one_ready got %b exp 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_dropped got %b exp 0", bus.out_valid); end
    drive(1'b1, 2'b01, 16'hF00D, 5'd9);
    step();
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    checks++; if (bus.out_data !== 32'hFFFF_F00D) begin errors++; $display("FAIL fl_recover_data got %h exp fffff00d", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd9) begin errors++; $display("FAIL fl_recover_tag got %0d exp 9", bus.out_tag); end
    step();
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 16'hBEEF, 5'd10);
    step();
    drive(1'b1, 2'b10, 16'hCAFE, 5'd11);
    step();
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rf_full_ready got %b exp 0", bus.in_ready); end
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rf_data got %h exp 00000000", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd0) begin errors++; $display("FAIL rf_tag got %0d exp 0", bus.out_tag); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rf_ready got %b exp 1", bus.in_ready); end
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rf_after_release got %b exp 0", bus.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 5'd0);
    #1;
    reset = 1'b1;
    #1;
    test_reset();
    step();
    reset = 1'b0;
    step();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imm_extend_pipe
